bcd_entry_controller: RTL and testbench

//   Collects up to two decimal keystrokes (ASCII) from the terminal receive path into a 2-digit packed BCD buffer.
//   On Enter, it runs an 8-step shift/subtract-3 BCD-to-binary conversion, one step per clock.
//   It then presents the 8-bit binary value on a valid/ready handshake.
//   It sits between the UART RX byte stream and any consumer of numeric operands (address/count entry).

---
 rtl/bcd_entry_controller_pkg.sv | 18 +
 rtl/bcd_entry_controller_dabble_step.sv | 11 +
 rtl/bcd_entry_controller.sv | 125 ++++++++++++
 tb/tb_bcd_entry_controller.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bcd_entry_controller_pkg.sv
// bcd_entry_controller_pkg: terminal key codes, FSM states and digit decode shared by the entry controller
package bcd_entry_controller_pkg;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_BS  = 8'h08;
   localparam logic [7:0] ASCII_ESC = 8'h1B;
   localparam logic [7:0] ASCII_0   = 8'h30;
   localparam logic [7:0] ASCII_9   = 8'h39;
   typedef enum logic [2:0] {
      S_EMPTY   = 3'd0,
      S_ONE     = 3'd1,
      S_TWO     = 3'd2,
      S_CONVERT = 3'd3,
      S_OUTPUT  = 3'd4
   } state_t;
   function automatic logic is_digit(input logic [7:0] c);
      return (c >= ASCII_0) && (c <= ASCII_9);
   endfunction
endpackage

// File: rtl/bcd_entry_controller_dabble_step.sv
// bcd_entry_controller_dabble_step: one shift-right / subtract-3 iteration of BCD-to-binary conversion
module bcd_entry_controller_dabble_step (
   input  logic [15:0] din_i,
   output logic [15:0] dout_o
);
   logic [15:0] sh;
   assign sh = din_i >> 1;
   assign dout_o = {(sh[15:12] >= 4'd8) ? sh[15:12] - 4'd3 : sh[15:12],
                    (sh[11:8]  >= 4'd8) ? sh[11:8]  - 4'd3 : sh[11:8],
                    sh[7:0]};
endmodule

// File: rtl/bcd_entry_controller.sv
// bcd_entry_controller: collects two ASCII digits, converts the BCD entry to binary, hands it out on valid/ready
module bcd_entry_controller
   import bcd_entry_controller_pkg::*;
#(
   parameter logic [7:0] ENTER_CODE = ASCII_CR,
   parameter logic [7:0] BS_CODE    = ASCII_BS,
   parameter logic [7:0] ESC_CODE   = ASCII_ESC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] bin_out,
   output logic       bin_valid,
   input  logic       bin_ready,
   output logic [7:0] bcd_disp,
   output logic [1:0] digit_cnt,
   output logic       busy,
   output logic       err
);
   state_t      state_q, state_d;
   logic [7:0]  bcd_q, bcd_d;
   logic [15:0] temp_q, temp_d, step_out;
   logic [2:0]  step_q, step_d;
   logic [7:0]  bin_out_q, bin_out_d;
   logic        bin_valid_q, bin_valid_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [1:0]  cnt_q, cnt_d;

   bcd_entry_controller_dabble_step u_step (.din_i(temp_q), .dout_o(step_out));

   // state and output registers, all cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_EMPTY;
         bcd_q       <= 8'h00;
         temp_q      <= 16'h0000;
         step_q      <= 3'd0;
         bin_out_q   <= 8'h00;
         bin_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         bcd_q       <= bcd_d;
         temp_q      <= temp_d;
         step_q      <= step_d;
         bin_out_q   <= bin_out_d;
         bin_valid_q <= bin_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   // keystroke decode, conversion sequencing and output handshake
   always_comb begin
      state_d     = state_q;
      bcd_d       = bcd_q;
      temp_d      = temp_q;
      step_d      = step_q;
      bin_out_d   = bin_out_q;
      bin_valid_d = bin_valid_q;
      err_d       = 1'b0;
      case (state_q)
         S_EMPTY, S_ONE, S_TWO: begin
            if (rx_valid) begin
               if (is_digit(rx_data)) begin
                  if (state_q == S_TWO) err_d = 1'b1;
                  else begin
                     bcd_d   = {bcd_q[3:0], rx_data[3:0]};
                     state_d = (state_q == S_EMPTY) ? S_ONE : S_TWO;
                  end
               end else if (rx_data == BS_CODE) begin
                  if (state_q == S_EMPTY) err_d = 1'b1;
                  else begin
                     bcd_d   = (state_q == S_TWO) ? {4'h0, bcd_q[7:4]} : 8'h00;
                     state_d = (state_q == S_TWO) ? S_ONE : S_EMPTY;
                  end
               end else if (rx_data == ESC_CODE) begin
                  bcd_d   = 8'h00;
                  state_d = S_EMPTY;
               end else if (rx_data == ENTER_CODE) begin
                  if (state_q == S_EMPTY) err_d = 1'b1;
                  else begin
                     temp_d  = {bcd_q, 8'h00};
                     step_d  = 3'd0;
                     state_d = S_CONVERT;
                  end
               end else err_d = 1'b1;
            end
         end
         S_CONVERT: begin
            err_d  = rx_valid;
            temp_d = step_out;
            step_d = step_q + 3'd1;
            if (step_q == 3'd7) begin
               bin_out_d   = step_out[7:0];
               bin_valid_d = 1'b1;
               state_d     = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            err_d = rx_valid;
            if (bin_ready) begin
               bin_valid_d = 1'b0;
               bcd_d       = 8'h00;
               state_d     = S_EMPTY;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      busy_d = (state_d == S_CONVERT) || (state_d == S_OUTPUT);
      cnt_d  = (state_d == S_ONE) ? 2'd1 : (state_d == S_TWO) ? 2'd2 : (state_d == S_EMPTY) ? 2'd0 : cnt_q;
   end

   assign bin_out   = bin_out_q;
   assign bin_valid = bin_valid_q;
   assign bcd_disp  = bcd_q;
   assign digit_cnt = cnt_q;
   assign busy      = busy_q;
   assign err       = err_q;
endmodule

// File: tb/tb_bcd_entry_controller.sv
// tb_bcd_entry_controller: scoreboard bench for keystroke entry, conversion latency and handshake
module tb_bcd_entry_controller;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] bin_out;
   logic       bin_valid;
   logic       bin_ready = 1'b1;
   logic [7:0] bcd_disp;
   logic [1:0] digit_cnt;
   logic       busy;
   logic       err;
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] sb[$];

   localparam logic [7:0] CR = 8'h0D, BS = 8'h08, ESC = 8'h1B;

   bcd_entry_controller dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .bin_out(bin_out), .bin_valid(bin_valid), .bin_ready(bin_ready),
      .bcd_disp(bcd_disp), .digit_cnt(digit_cnt), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // pop the scoreboard on every accepted result
   always @(negedge clk) begin
      if (!reset && bin_valid && bin_ready) begin
         if (sb.size() == 0) check("unexpected_out", {8'h00, bin_out}, 16'hFFFF);
         else check("bin_out", {8'h00, bin_out}, {8'h00, sb.pop_front()});
      end
   end

   task automatic send(input logic [7:0] c, input logic exp_err);
      @(posedge clk); #1;
      rx_data = c;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      check("err", {15'h0, err}, {15'h0, exp_err});
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bin_valid) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic convert(input logic [7:0] exp, input logic [1:0] cnt);
      int n;
      sb.push_back(exp);
      send(CR, 1'b0);
      check("busy", {15'h0, busy}, 16'h1);
      check("cnt_held", {14'h0, digit_cnt}, {14'h0, cnt});
      wait_valid(n);
      check("latency", n[15:0], 16'd8);
      @(posedge clk); #1;
      check("valid_drop", {15'h0, bin_valid}, 16'h0);
      check("cnt_clear", {14'h0, digit_cnt}, 16'h0);
      check("disp_clear", {8'h0, bcd_disp}, 16'h0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_out", {8'h0, bin_out}, 16'h0);
      check("rst_valid", {15'h0, bin_valid}, 16'h0);
      check("rst_disp", {8'h0, bcd_disp}, 16'h0);
      check("rst_busy", {15'h0, busy}, 16'h0);
      // basic conversions
      send("4", 1'b0); send("2", 1'b0);
      check("disp42", {8'h0, bcd_disp}, 16'h42);
      convert(8'h2A, 2'd2);
      send("9", 1'b0); send("9", 1'b0); convert(8'h63, 2'd2);
      send("7", 1'b0); convert(8'h07, 2'd1);
      send("0", 1'b0); convert(8'h00, 2'd1);
      // overflow digit and backspace
      send("1", 1'b0); send("2", 1'b0); send("3", 1'b1);
      check("disp12", {8'h0, bcd_disp}, 16'h12);
      convert(8'h0C, 2'd2);
      send("5", 1'b0); send("6", 1'b0); send(BS, 1'b0);
      check("disp_bs", {8'h0, bcd_disp}, 16'h05);
      check("cnt_bs", {14'h0, digit_cnt}, 16'h1);
      send("8", 1'b0);
      check("disp58", {8'h0, bcd_disp}, 16'h58);
      convert(8'h3A, 2'd2);
      // rejected keys in EMPTY, ESC
      send(CR, 1'b1);
      send(BS, 1'b1);
      repeat (3) @(posedge clk); #1;
      check("no_valid", {15'h0, bin_valid}, 16'h0);
      check("no_busy", {15'h0, busy}, 16'h0);
      send("A", 1'b1);
      check("cnt_A", {14'h0, digit_cnt}, 16'h0);
      send("3", 1'b0);
      check("cnt3", {14'h0, digit_cnt}, 16'h1);
      send(ESC, 1'b0);
      check("cnt_esc", {14'h0, digit_cnt}, 16'h0);
      check("disp_esc", {8'h0, bcd_disp}, 16'h0);
      // back-pressure with overrun byte
      bin_ready = 1'b0;
      send("2", 1'b0); send("5", 1'b0);
      sb.push_back(8'h19);
      send(CR, 1'b0);
      wait_valid(n);
      check("latency_hold", n[15:0], 16'd8);
      for (int i = 0; i < 20; i++) begin
         if (i == 10) send("7", 1'b1);
         else begin
            @(posedge clk); #1;
         end
         check("hold_out", {8'h0, bin_out}, 16'h19);
         check("hold_valid", {15'h0, bin_valid}, 16'h1);
      end
      check("hold_disp", {8'h0, bcd_disp}, 16'h25);
      bin_ready = 1'b1;
      @(posedge clk); #1;
      check("ready_drop", {15'h0, bin_valid}, 16'h0);
      check("ready_busy", {15'h0, busy}, 16'h0);
      // reset mid-conversion
      send("8", 1'b0); send("6", 1'b0); send(CR, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("abort_out", {8'h0, bin_out}, 16'h0);
      check("abort_valid", {15'h0, bin_valid}, 16'h0);
      check("abort_busy", {15'h0, busy}, 16'h0);
      check("abort_cnt", {14'h0, digit_cnt}, 16'h0);
      check("abort_disp", {8'h0, bcd_disp}, 16'h0);
      check("abort_err", {15'h0, err}, 16'h0);
      reset = 1'b0;
      send("3", 1'b0); convert(8'h03, 2'd1);
      repeat (2) @(posedge clk);
      check("sb_empty", sb.size(), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
